// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, CPU-level
// default geometry and small request-decoding helpers.
package dmem_responder_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_t;

    function automatic logic req_fire(input logic re, input logic we);
        return re | we;
    endfunction

    // A request with both strobes set is committed as a store.
    function automatic logic req_is_store(input logic re, input logic we);
        return we | (re & we);
    endfunction

    function automatic logic req_conflict(input logic re, input logic we);
        return re & we;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM: combinational read, write on the rising clock edge.
// Contents are deliberately left unreset.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: accepts one request, inserts LATENCY wait
// states, then commits the store or returns load data with a one-cycle rdy.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] sdata,
    input  logic              re_mem,
    input  logic              we_mem,
    output logic [DATA_W-1:0] ldata,
    output logic              rdy,
    output logic              busy,
    output logic              err
);

    localparam logic [DMEM_CNT_W-1:0] LAT_INIT = DMEM_CNT_W'(LATENCY);

    dmem_state_t           r_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic                  r_store;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_sdata;
    logic [DATA_W-1:0]     r_ldata;
    logic                  r_rdy;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_to_resp;
    logic [ADDR_W-1:0]     w_ram_addr;
    logic                  w_ram_we;
    logic [DATA_W-1:0]     w_ram_rdata;

    generate
        if (ADDR_W < 16) begin : g_addr_hi
            logic w_addr_hi_unused;
            assign w_addr_hi_unused = ^addr[15:ADDR_W];
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && req_fire(re_mem, we_mem);

    // Entering RESP this edge: straight from IDLE at zero latency, else on the last wait state.
    assign w_to_resp = (w_accept && (LATENCY == 0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == DMEM_CNT_W'(1)));

    // In IDLE the live address feeds the RAM so a zero-latency load reads in time.
    assign w_ram_addr = (r_state == ST_IDLE) ? addr[ADDR_W-1:0] : r_addr;
    assign w_ram_we   = (r_state == ST_RESP) && r_store;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_array (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_sdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr[ADDR_W-1:0];
            r_sdata <= sdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_ldata <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_store <= req_is_store(re_mem, we_mem);
                        r_err   <= req_conflict(re_mem, we_mem);
                        r_cnt   <= LAT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - DMEM_CNT_W'(1);
                    if (r_cnt == DMEM_CNT_W'(1)) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_to_resp) begin
                r_rdy <= 1'b1;
                if (r_state == ST_IDLE) begin
                    if (!req_is_store(re_mem, we_mem)) begin
                        r_ldata <= w_ram_rdata;
                    end
                end else if (!r_store) begin
                    r_ldata <= w_ram_rdata;
                end
            end
        end
    end

    assign ldata = r_ldata;
    assign rdy   = r_rdy;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule
